// File: rtl/branch_pred_pkg.sv
// Shared types and sizing for the branch predictor: BTB geometry,
// 2-bit counter encodings and the BTB entry layout.
package branch_pred_pkg;

    localparam int BTB_DEPTH = 16;
    localparam int IDX_W     = 4;
    localparam int TAG_W     = 26;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [31:0]       target;
        ctr_state_t        ctr;
    } btb_entry_t;

    // Weak-taken and strong-taken both predict taken.
    function automatic logic predicts_taken(input ctr_state_t c);
        return c >= WT;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, execute-resolve and statistics signals exchanged between
// the pipeline (master) and the branch predictor (slave).
interface branch_predictor_if;

    logic [31:0] IF_PC;
    logic        IF_branch_taken;
    logic [31:0] IF_pred_target;
    logic        EX_branch;
    logic [31:0] EX_PCPlus4;
    logic        EX_taken;
    logic [31:0] EX_target;
    logic        EX_pred_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output IF_PC, EX_branch, EX_PCPlus4, EX_taken, EX_target, EX_pred_taken,
        input  IF_branch_taken, IF_pred_target, mispredict, redirect_pc,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  IF_PC, EX_branch, EX_PCPlus4, EX_taken, EX_target, EX_pred_taken,
        output IF_branch_taken, IF_pred_target, mispredict, redirect_pc,
               stat_branches, stat_mispredicts
    );

endinterface

// File: rtl/bp_sat_counter.sv
// Two-bit saturating counter step: moves one state toward the actual
// outcome and sticks at SNT / ST.
module bp_sat_counter
    import branch_pred_pkg::*;
(
    input  ctr_state_t state,
    input  logic       taken,
    output ctr_state_t next_state
);

    always_comb begin
        // NOTE: default first so every path assigns next_state; no latch.
        next_state = state;
        if (taken) begin
            if (state != ST) next_state = ctr_state_t'(state + 2'd1);
        end else begin
            if (state != SNT) next_state = ctr_state_t'(state - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// 16-entry direct-mapped BTB with 2-bit counters: zero-latency lookup at
// fetch, training and misprediction detection at execute.
module branch_predictor
    import branch_pred_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
);

    btb_entry_t       btb [BTB_DEPTH];
    btb_entry_t       lk_entry;
    btb_entry_t       ex_entry;
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [31:0]      ex_pc;
    logic             lk_hit;
    logic             ex_hit;
    logic             misp;
    ctr_state_t       ctr_next;
    logic [31:0]      stat_branches;
    logic [31:0]      stat_mispredicts;
    logic             unused_low_bits;

    // Fetch-side lookup reads the registered table, so a same-cycle update
    // only becomes visible on the following cycle.
    assign lk_idx   = bp.IF_PC[IDX_W+1:2];
    assign lk_entry = btb[lk_idx];
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == bp.IF_PC[31:IDX_W+2]);

    assign bp.IF_branch_taken = rst_n && lk_hit && predicts_taken(lk_entry.ctr);
    assign bp.IF_pred_target  = (rst_n && lk_hit) ? lk_entry.target : 32'd0;

    assign ex_pc    = bp.EX_PCPlus4 - 32'd4;
    assign ex_idx   = ex_pc[IDX_W+1:2];
    assign ex_entry = btb[ex_idx];
    assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_pc[31:IDX_W+2]);

    assign misp           = bp.EX_branch && (bp.EX_pred_taken != bp.EX_taken);
    assign bp.mispredict  = misp;
    assign bp.redirect_pc = bp.EX_taken ? bp.EX_target : bp.EX_PCPlus4;

    assign bp.stat_branches    = stat_branches;
    assign bp.stat_mispredicts = stat_mispredicts;

    assign unused_low_bits = ^{bp.IF_PC[1:0], ex_pc[1:0]};

    bp_sat_counter u_sat_counter (
        .state      (ex_entry.ctr),
        .taken      (bp.EX_taken),
        .next_state (ctr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is small enough to reset as flops; a cleared
            // table after reset is part of the predictor's contract.
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (bp.EX_branch) begin
            // NOTE: non-blocking throughout, so the lookup path and counter
            // step both see pre-edge table contents.
            if (ex_hit) begin
                btb[ex_idx].ctr    <= ctr_next;
                btb[ex_idx].target <= bp.EX_target;
            end else if (bp.EX_taken) begin
                btb[ex_idx] <= '{valid: 1'b1, tag: ex_pc[31:IDX_W+2],
                                 target: bp.EX_target, ctr: WT};
            end
            if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
            if (misp && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have one clock and one reset: the design uses one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-002 SHALL have port: clk  in  1  pipeline clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: IF_PC  in  32  fetch-stage PC being looked up.
REQ-005 SHALL have port: IF_branch_taken  out  1  prediction for IF_PC; carried into the ID/EX register.
REQ-006 SHALL have port: IF_pred_target  out  32  predicted target; valid when IF_branch_taken=1.
REQ-007 SHALL have port: EX_branch  in  1  conditional branch (beq/bne/bgtz) resolving in EX this cycle; 0 when squashed or stalled.
REQ-008 SHALL have port: EX_PCPlus4  in  32  PC+4 of the resolving branch.
REQ-009 SHALL have port: EX_taken  in  1  actual branch outcome.
REQ-010 SHALL have port: EX_target  in  32  computed branch target.
REQ-011 SHALL have port: EX_pred_taken  in  1  prediction that travelled with the branch (IE_branch_taken).
REQ-012 SHALL have port: mispredict  out  1  flush request for IF/ID and ID/EX.
REQ-013 SHALL have port: redirect_pc  out  32  corrected fetch PC; valid when mispredict=1.
REQ-014 SHALL have port: stat_branches  out  32  count of resolved branches.
REQ-015 SHALL have port: stat_mispredicts  out  32  count of mispredictions.

Function
REQ-016 SHALL hold 16 direct-mapped BTB entries, each with valid, tag, target[31:0] and a 2-bit counter; index = PC[5:2], tag = PC[31:6].
REQ-017 SHALL use these counter states: SNT=00, WNT=01, WT=10, ST=11; the prediction is taken iff the counter is >= WT.
REQ-018 SHALL perform lookup combinationally (0-cycle latency): IF_branch_taken = valid & tag match & counter[1]; IF_pred_target = entry target, or 0 on a miss.
REQ-019 SHALL derive the resolving branch PC as EX_PC = EX_PCPlus4 - 4 (32-bit wrap-around).
REQ-020 SHALL compute mispredict = EX_branch & (EX_pred_taken != EX_taken), combinationally.
REQ-021 SHALL compute redirect_pc = EX_taken ? EX_target : EX_PCPlus4.
REQ-022 SHALL apply the following update on a rising edge with EX_branch=1 and a hit: taken -> counter +1, saturating at ST; not taken -> counter -1, saturating at SNT; target rewritten with EX_target.
REQ-023 SHALL, on EX_branch=1 with a miss and EX_taken=1, allocate the entry: valid=1, tag, target=EX_target, counter=WT, replacing any occupant.
REQ-024 SHALL NOT allocate an entry on EX_branch=1 with a miss and EX_taken=0.
REQ-025 SHALL, when the same index is looked up and updated in one cycle, return the pre-update state from the lookup; the new state becomes visible next cycle.
REQ-026 SHALL, when EX_branch=0, leave the table and statistics unchanged.
REQ-027 SHALL increment stat_branches on each EX_branch=1 and stat_mispredicts on each mispredict=1; both saturate at 32'hFFFFFFFF and do not wrap.

Reset
REQ-028 SHALL, while rst_n=0, clear all valid bits, set all counters to WNT, and set targets, tags and both statistics to 0.
REQ-029 SHALL, during reset, drive IF_branch_taken=0 and IF_pred_target=0; mispredict and redirect_pc remain functions of the inputs only.
REQ-030 SHALL abort any update in flight when reset is asserted mid-operation; the first update after release SHALL see a cleared table.

Structure
REQ-031 SHALL place the counter state encodings, BTB depth (16), index width (4) and tag width (26) in shared package branch_pred_pkg.
REQ-032 SHALL implement the saturating counter update as sub-module bp_sat_counter (inputs: state, taken; output: next state).

Verification
REQ-033 SHALL cover cold miss: after reset, IF_PC=0x00400010 -> IF_branch_taken=0, IF_pred_target=0.
REQ-034 SHALL cover allocate and hit: EX_branch=1, EX_PCPlus4=0x00400014, EX_taken=1, EX_target=0x00400100, EX_pred_taken=0 -> mispredict=1, redirect_pc=0x00400100; next cycle IF_PC=0x00400010 -> IF_branch_taken=1, IF_pred_target=0x00400100.
REQ-035 SHALL cover saturation: three taken updates to one entry -> counter ST; two not-taken updates -> WNT, prediction 0; a further two -> SNT, then remains SNT.
REQ-036 SHALL cover aliasing: after the allocate in REQ-034, IF_PC=0x00800010 (same index, different tag) -> IF_branch_taken=0; a taken update at 0x00800010 replaces the entry, after which 0x00400010 misses.
REQ-037 SHALL cover same-cycle lookup and update: a not-taken update driving the counter WT->WNT together with a lookup of the same PC -> the lookup returns 1 that cycle and 0 the next.
REQ-038 SHALL cover correct not-taken prediction and mid-run reset: EX_pred_taken=0, EX_taken=0 -> mispredict=0, redirect_pc=EX_PCPlus4, stat_branches+1; rst_n pulsed low mid-run -> stats=0 and all lookups miss.
